fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry instruction/PC+4 queue between the fetch and decode stages.
- Decouples instruction-memory fetch from decode stalls: fetch keeps pushing while stallD holds decode, until the queue fills.
- Flush (feclr = pcsrcD | jumpD) discards every queued entry in one cycle.
- When the queue is empty it presents a NOP (all-zero instruction) to decode.

Parameters:
- IW, 32, instruction width in bits.
- PCW, 32, PC+4 width in bits.
- DEPTH, 4, number of queue entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- push_valid  input  1  fetch offers an entry this cycle.
- push_instr  input  IW  fetched instruction.
- push_pcplus4  input  PCW  PC+4 of the fetched instruction.
- push_ready  output  1  queue accepts a push this cycle.
- pop_ready  input  1  decode consumes the head entry (driven by ~stallD).
- pop_valid  output  1  head entry is valid.
- instrD  output  IW  head instruction; 0 when not pop_valid.
- pcplus4D  output  PCW  head PC+4; 0 when not pop_valid.
- flush  input  1  discard all entries (feclr).
- count  output  $clog2(DEPTH+1)  current occupancy.
- ovf_err  output  1  sticky flag: a push was attempted while push_ready=0.

Behaviour:
- Storage: DEPTH-entry circular buffer.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is held in a separate register.
- Reset (reset=0, asynchronous): pointers=0, count=0, pop_valid=0, instrD=0, pcplus4D=0, ovf_err=0, push_ready=1. Storage contents are don't-care.
- push_ready = (count<DEPTH) | (pop_ready & pop_valid). This is combinational, so a full queue accepts a push in the same cycle it pops.
- pop_valid = (count!=0). instrD/pcplus4D are driven combinationally from the entry at the read pointer; both are forced to 0 when count=0.
- Push fire = push_valid & push_ready & ~flush. On the clock edge, writes the entry at the write pointer and increments the write pointer.
- Pop fire = pop_ready & pop_valid & ~flush. On the clock edge, increments the read pointer.
- count update on each edge: +1 for push only, -1 for pop only, unchanged for both or neither.
- Flush has priority over everything: pointers and count go to 0 on the next edge, and any push or pop in that cycle is dropped. Decode sees the NOP from the next cycle.
- Latency: an entry pushed at edge N is visible at the head from cycle N+1 (1-cycle latency).
- Pop while empty: ignored, with no pointer change.
- Push while not ready (full and no pop):
  - the entry is dropped;
  - the queue is unchanged;
  - ovf_err is set and stays 1 until reset.
- Push during flush: silently dropped; ovf_err is not set.
- Wrap-around: pointer DEPTH-1 increments to 0. Ordering is strictly FIFO across the wrap.
- Reset asserted mid-operation: immediate return to the reset values, independent of clk.

Optional Feature:
- Macro FETCHQ_BYPASS_EN.
- Defined:
  - When count=0 and push_valid=1 and flush=0, the push data is forwarded combinationally to instrD/pcplus4D with pop_valid=1.
  - If pop_ready=1 in that cycle, the entry is consumed and is not written (count stays 0).
  - If pop_ready=0, it is written normally.
  - Empty-queue latency becomes 0 cycles.
- Not defined: no combinational path from push_* to pop-side outputs; 1-cycle latency always.

Test Plan:
- Reset with push_valid=1 → count=0, pop_valid=0, instrD=0, ovf_err=0 throughout. Release reset; push 0x20080005/pc4 0x4 → next cycle pop_valid=1, instrD=0x20080005, pcplus4D=0x4.
- Fill: pop_ready=0, push 4 entries 0xA0..0xA3 → count=4, push_ready=0. A 5th push 0xA4 → dropped, ovf_err=1. Then pop_ready=1 → heads read 0xA0, 0xA1, 0xA2, 0xA3 in order, then count=0.
- Full with simultaneous push/pop: count=4, push 0xB0 with pop_ready=1 → push_ready=1, count stays 4, 0xB0 is read after the remaining 3 entries.
- Flush: count=3, assert flush with push_valid=1 and pop_ready=1 → next cycle count=0, instrD=0, ovf_err unchanged, pushed entry absent.
- Wrap: 10 push/pop cycles alternating at count≤2 with values 0xC0..0xC9 → output order exactly 0xC0..0xC9, no loss.
- Bypass (FETCHQ_BYPASS_EN): empty, push 0xD0 with pop_ready=1 → same cycle pop_valid=1, instrD=0xD0, next cycle count=0. Without the macro → instrD=0 that cycle, 0xD0 the next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction / PC+4 queue between fetch and decode; presents a NOP when empty.
// Optional FETCHQ_BYPASS_EN forwards a push straight to decode while the queue is empty.
module fetch_queue #(
    parameter int IW    = 32,
    parameter int PCW   = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [IW-1:0]              push_instr,
    input  logic [PCW-1:0]             push_pcplus4,
    output logic                       push_ready,
    input  logic                       pop_ready,
    output logic                       pop_valid,
    output logic [IW-1:0]              instrD,
    output logic [PCW-1:0]             pcplus4D,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf_err
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    logic [IW-1:0]   instrMem [DEPTH];
    logic [PCW-1:0]  pcMem    [DEPTH];
    logic [PTRW-1:0] rdPtr, wrPtr;
    logic [CNTW-1:0] cntQ;
    logic            ovfQ;

    logic headValid, bypassActive, pushFire, popFire, wrEn, rdEn, ovfSet;

    assign headValid = (cntQ != '0);

`ifdef FETCHQ_BYPASS_EN
    // Bypass is suppressed while reset is held so decode never sees a live entry in reset.
    assign bypassActive = reset & ~headValid & push_valid & ~flush;
`else
    assign bypassActive = 1'b0;
`endif

    always_comb begin
        pop_valid = headValid | bypassActive;
        instrD    = '0;
        pcplus4D  = '0;
        if (headValid) begin
            instrD   = instrMem[rdPtr];
            pcplus4D = pcMem[rdPtr];
        end else if (bypassActive) begin
            instrD   = push_instr;
            pcplus4D = push_pcplus4;
        end
    end

    assign push_ready = (cntQ < FULL_CNT) | (pop_ready & pop_valid);
    assign pushFire   = push_valid & push_ready & ~flush;
    assign popFire    = pop_ready & pop_valid & ~flush;
    assign ovfSet     = push_valid & ~push_ready & ~flush;

    // A bypassed entry consumed in the same cycle never touches storage or pointers.
    assign wrEn = pushFire & ~(bypassActive & pop_ready);
    assign rdEn = popFire & ~bypassActive;

    assign count   = cntQ;
    assign ovf_err = ovfQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cntQ  <= '0;
            ovfQ  <= 1'b0;
        end else begin
            if (ovfSet)
                ovfQ <= 1'b1;
            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
                cntQ  <= '0;
            end else begin
                if (wrEn)
                    wrPtr <= wrPtr + PTRW'(1);
                if (rdEn)
                    rdPtr <= rdPtr + PTRW'(1);
                if (wrEn && !rdEn)
                    cntQ <= cntQ + CNTW'(1);
                else if (rdEn && !wrEn)
                    cntQ <= cntQ - CNTW'(1);
            end
        end
    end

    // Storage holds data only; its contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            instrMem[wrPtr] <= push_instr;
            pcMem[wrPtr]    <= push_pcplus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4); expectations follow FETCHQ_BYPASS_EN.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_instr;
    logic [31:0] push_pcplus4;
    logic        push_ready;
    logic        pop_ready;
    logic        pop_valid;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        flush;
    logic [2:0]  count;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.IW(32), .PCW(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_instr  (push_instr),
        .push_pcplus4(push_pcplus4),
        .push_ready  (push_ready),
        .pop_ready   (pop_ready),
        .pop_valid   (pop_valid),
        .instrD      (instrD),
        .pcplus4D    (pcplus4D),
        .flush       (flush),
        .count       (count),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setPush(input logic v, input logic [31:0] ins, input logic [31:0] pc4);
        push_valid   = v;
        push_instr   = ins;
        push_pcplus4 = pc4;
    endtask

    initial begin
        reset     = 1'b0;
        pop_ready = 1'b0;
        flush     = 1'b0;
        setPush(1'b1, 32'h2008_0005, 32'h4);

        // reset held with a push offered
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_instrD", instrD, 32'd0);
        check("rst_ovf", 32'(ovf_err), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd1);

        // first push after reset release
        reset = 1'b1;
        tick();
        setPush(1'b0, 32'h0, 32'h0);
        #1;
        check("first_pop_valid", 32'(pop_valid), 32'd1);
        check("first_instrD", instrD, 32'h2008_0005);
        check("first_pcplus4D", pcplus4D, 32'h4);
        check("first_count", 32'(count), 32'd1);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
        check("first_drain", 32'(count), 32'd0);

        // fill to capacity, then overflow
        for (int i = 0; i < 4; i++) begin
            setPush(1'b1, 32'hA0 + i, 32'h100 + 4 * i);
            tick();
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_push_ready", 32'(push_ready), 32'd0);
        setPush(1'b1, 32'hA4, 32'h110);
        tick();
        setPush(1'b0, 32'h0, 32'h0);
        #1;
        check("ovf_set", 32'(ovf_err), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        pop_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_instr%0d", i), instrD, 32'hA0 + i);
            check($sformatf("drain_pc%0d", i), pcplus4D, 32'h100 + 4 * i);
            tick();
        end
        pop_ready = 1'b0;
        #1;
        check("drain_count", 32'(count), 32'd0);
        check("drain_pop_valid", 32'(pop_valid), 32'd0);
        check("drain_nop", instrD, 32'd0);

        // full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            setPush(1'b1, 32'h90 + i, 32'h200 + 4 * i);
            tick();
        end
        setPush(1'b1, 32'hB0, 32'h210);
        pop_ready = 1'b1;
        #1;
        check("fullpp_push_ready", 32'(push_ready), 32'd1);
        check("fullpp_head", instrD, 32'h90);
        tick();
        setPush(1'b0, 32'h0, 32'h0);
        #1;
        check("fullpp_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fullpp_order%0d", i), instrD, (i < 3) ? 32'h91 + i : 32'hB0);
            tick();
        end
        check("fullpp_empty", 32'(count), 32'd0);
        check("fullpp_ovf_sticky", 32'(ovf_err), 32'd1);

        // flush beats a concurrent push and pop
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setPush(1'b1, 32'hE0 + i, 32'h300 + 4 * i);
            tick();
        end
        check("flush_pre_count", 32'(count), 32'd3);
        setPush(1'b1, 32'hEE, 32'h3EE);
        pop_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        pop_ready = 1'b0;
        setPush(1'b0, 32'h0, 32'h0);
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_instrD", instrD, 32'd0);
        check("flush_pcplus4D", pcplus4D, 32'd0);
        check("flush_ovf", 32'(ovf_err), 32'd1);
        setPush(1'b1, 32'hF0, 32'h3F0);
        tick();
        setPush(1'b0, 32'h0, 32'h0);
        #1;
        check("flush_after_head", instrD, 32'hF0);
        check("flush_after_count", 32'(count), 32'd1);
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;

        // alternating push/pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            setPush(1'b1, 32'hC0 + i, 32'h400 + 4 * i);
            tick();
            setPush(1'b0, 32'h0, 32'h0);
            pop_ready = 1'b1;
            #1;
            check($sformatf("wrap%0d", i), instrD, 32'hC0 + i);
            tick();
            pop_ready = 1'b0;
        end
        check("wrap_count", 32'(count), 32'd0);

        // empty-queue push with decode ready
        setPush(1'b1, 32'hD0, 32'h4D0);
        pop_ready = 1'b1;
        #1;
`ifdef FETCHQ_BYPASS_EN
        check("byp_same_valid", 32'(pop_valid), 32'd1);
        check("byp_same_instr", instrD, 32'hD0);
        check("byp_same_pc", pcplus4D, 32'h4D0);
        tick();
        setPush(1'b0, 32'h0, 32'h0);
        pop_ready = 1'b0;
        #1;
        check("byp_next_count", 32'(count), 32'd0);
        check("byp_next_valid", 32'(pop_valid), 32'd0);
`else
        check("byp_same_valid", 32'(pop_valid), 32'd0);
        check("byp_same_instr", instrD, 32'd0);
        tick();
        setPush(1'b0, 32'h0, 32'h0);
        #1;
        check("byp_next_instr", instrD, 32'hD0);
        check("byp_next_count", 32'(count), 32'd1);
        tick();
        pop_ready = 1'b0;
        check("byp_drain_count", 32'(count), 32'd0);
`endif

        // asynchronous reset mid-operation
        for (int i = 0; i < 2; i++) begin
            setPush(1'b1, 32'h50 + i, 32'h500);
            tick();
        end
        setPush(1'b0, 32'h0, 32'h0);
        check("midrst_pre_count", 32'(count), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_pop_valid", 32'(pop_valid), 32'd0);
        check("midrst_instrD", instrD, 32'd0);
        check("midrst_ovf", 32'(ovf_err), 32'd0);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
